block_scan_counter: RTL

//  Generates coefficient coordinates for the block-transform and entropy stages.

---
 rtl/block_scan_counter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/block_scan_counter.sv
// Block scan counter: walks each NxN block in raster or zigzag order and
// steps through a BLKS_X x BLKS_Y grid of blocks, one coefficient per go.
module block_scan_counter #(
  parameter int LOG2_N = 3,
  parameter int BLKS_X = 4,
  parameter int BLKS_Y = 4,
  parameter int BX_W   = (BLKS_X > 1) ? $clog2(BLKS_X) : 1,
  parameter int BY_W   = (BLKS_Y > 1) ? $clog2(BLKS_Y) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  restart,
  input  logic                  go,
  input  logic                  zigzag,
  output logic [LOG2_N-1:0]     u,
  output logic [LOG2_N-1:0]     v,
  output logic [2*LOG2_N-1:0]   idx,
  output logic [BX_W-1:0]       blk_x,
  output logic [BY_W-1:0]       blk_y,
  output logic                  last_in_block,
  output logic                  done
);

  localparam int N = 1 << LOG2_N;
  localparam logic [LOG2_N-1:0]   L_EDGE = LOG2_N'(N - 1);
  localparam logic [2*LOG2_N-1:0] L_IDX  = (2*LOG2_N)'(N * N - 1);
  localparam logic [BX_W-1:0]     L_BX   = BX_W'(BLKS_X - 1);
  localparam logic [BY_W-1:0]     L_BY   = BY_W'(BLKS_Y - 1);

  logic [LOG2_N-1:0]   r_u, r_v;
  logic [2*LOG2_N-1:0] r_idx;
  logic [BX_W-1:0]     r_bx;
  logic [BY_W-1:0]     r_by;
  logic                r_mode;
  logic                r_dir;

  logic [LOG2_N-1:0]   w_u, w_v;
  logic [2*LOG2_N-1:0] w_idx;
  logic [BX_W-1:0]     w_bx;
  logic [BY_W-1:0]     w_by;
  logic                w_mode;
  logic                w_dir;

  logic w_last;
  logic w_done;
  logic w_blk_end;
  logic w_step;

  assign w_last    = (r_idx == L_IDX);
  assign w_done    = w_last & (r_bx == L_BX) & (r_by == L_BY);
  assign w_blk_end = ~restart & go & w_last & ~w_done;
  assign w_step    = ~restart & go & ~w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_u    <= '0;
      r_v    <= '0;
      r_idx  <= '0;
      r_bx   <= '0;
      r_by   <= '0;
      r_mode <= 1'b0;
      r_dir  <= 1'b1;
    end else begin
      r_u    <= w_u;
      r_v    <= w_v;
      r_idx  <= w_idx;
      r_bx   <= w_bx;
      r_by   <= w_by;
      r_mode <= w_mode;
      r_dir  <= w_dir;
    end
  end

  always_comb begin
    w_u    = r_u;
    w_v    = r_v;
    w_idx  = r_idx;
    w_bx   = r_bx;
    w_by   = r_by;
    w_mode = r_mode;
    w_dir  = r_dir;
    unique case (1'b1)
      restart: begin
        w_u    = '0;
        w_v    = '0;
        w_idx  = '0;
        w_bx   = '0;
        w_by   = '0;
        w_dir  = 1'b1;
        w_mode = zigzag;
      end
      w_blk_end: begin
        w_u   = '0;
        w_v   = '0;
        w_idx = '0;
        w_dir = 1'b1;
        if (r_bx == L_BX) begin
          w_bx = '0;
          w_by = r_by + 1'b1;
        end else begin
          w_bx = r_bx + 1'b1;
        end
      end
      w_step: begin
        w_idx = r_idx + 1'b1;
        if (!r_mode) begin
          if (r_v == L_EDGE) begin
            w_v = '0;
            w_u = r_u + 1'b1;
          end else begin
            w_v = r_v + 1'b1;
          end
        end else if (r_dir) begin
          // up-right diagonal; bounce off right edge before top edge
          if (r_v == L_EDGE) begin
            w_u   = r_u + 1'b1;
            w_dir = 1'b0;
          end else if (r_u == '0) begin
            w_v   = r_v + 1'b1;
            w_dir = 1'b0;
          end else begin
            w_u = r_u - 1'b1;
            w_v = r_v + 1'b1;
          end
        end else begin
          // down-left diagonal; bounce off bottom edge before left edge
          if (r_u == L_EDGE) begin
            w_v   = r_v + 1'b1;
            w_dir = 1'b1;
          end else if (r_v == '0) begin
            w_u   = r_u + 1'b1;
            w_dir = 1'b1;
          end else begin
            w_u = r_u + 1'b1;
            w_v = r_v - 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign u             = r_u;
  assign v             = r_v;
  assign idx           = r_idx;
  assign blk_x         = r_bx;
  assign blk_y         = r_by;
  assign last_in_block = w_last;
  assign done          = w_done;

endmodule
